// File: rtl/kodd_mem_pkg.sv
// Shared types and helpers for the KODD M-stage data memory responder.
package kodd_mem_pkg;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SRD  = 3'd1,
    VRD  = 3'd2,
    VWR  = 3'd3,
    RESP = 3'd4
  } dmem_state_t;

  // Word index of a byte address; bits above the RAM depth are masked off so addresses wrap.
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input int unsigned aw);
    return (addr >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/kodd_sram_sp.sv
// Single-port synchronous word RAM: one access per cycle, read data one cycle after the address.
module kodd_sram_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Read port only updates on read cycles so the output holds across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/kodd_dmem_responder.sv
// M-stage data memory responder: scalar and 4-lane vector loads/stores over one single-port RAM.
module kodd_dmem_responder
  import kodd_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemVecM,
  input  logic        MemWriteM,
  input  logic        MemWriteVecM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALUOutMVec [0:LANES-1],
  input  logic [31:0] WriteDataMVec [0:LANES-1],
  output logic [31:0] ReadDataM,
  output logic [31:0] ReadDataVecM [0:LANES-1],
  output logic        MemStallM
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t stateReg, stateNext;
  logic [1:0]  laneReg, laneNext;
  logic [1:0]  capIdx;
  logic [31:0] readDataReg;
  logic [31:0] vecReg [0:LANES-1];
  logic        capScalar, capVec;
  logic        ramEn, ramWe;
  logic [31:0] addrSel, ramWdata, ramRdata;
  logic [AW-1:0] ramAddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= IDLE;
      laneReg     <= '0;
      readDataReg <= '0;
    end else begin
      stateReg <= stateNext;
      laneReg  <= laneNext;
      if (capScalar) readDataReg <= ramRdata;
    end
  end

  always_comb begin
    stateNext = stateReg;
    laneNext  = laneReg;
    ramEn     = 1'b0;
    ramWe     = 1'b0;
    addrSel   = ALUOutMVec[laneReg];
    ramWdata  = WriteDataMVec[laneReg];
    MemStallM = 1'b0;
    capScalar = 1'b0;
    capVec    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (MemReqM) begin
          ramEn = 1'b1;
          if (MemVecM) begin
            ramWe     = MemWriteVecM;
            MemStallM = 1'b1;
            laneNext  = 2'd1;
            stateNext = MemWriteVecM ? VWR : VRD;
          end else begin
            addrSel  = ALUOutM;
            ramWdata = WriteDataM;
            ramWe    = MemWriteM;
            if (!MemWriteM) begin
              MemStallM = 1'b1;
              stateNext = SRD;
            end
          end
        end
      end
      SRD: begin
        capScalar = 1'b1;
        stateNext = IDLE;
      end
      VRD: begin
        ramEn     = 1'b1;
        MemStallM = 1'b1;
        capVec    = 1'b1;
        laneNext  = laneReg + 2'd1;
        if (laneReg == 2'd3) stateNext = RESP;
      end
      VWR: begin
        ramEn     = 1'b1;
        ramWe     = 1'b1;
        MemStallM = (laneReg != 2'd3);
        laneNext  = laneReg + 2'd1;
        if (laneReg == 2'd3) stateNext = IDLE;
      end
      RESP: begin
        capVec    = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        laneNext  = '0;
      end
    endcase
  end

  assign ramAddr = AW'(word_idx(addrSel, AW));
  // RAM data returned this cycle belongs to the lane issued one cycle earlier (lane 3 lands in RESP).
  assign capIdx  = laneReg - 2'd1;

  kodd_sram_sp #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) uSram (
    .clk   (clk),
    .en    (ramEn & reset),
    .we    (ramWe & reset),
    .addr  (ramAddr),
    .wdata (ramWdata),
    .rdata (ramRdata)
  );

  // Outputs bypass the RAM read port in the finishing cycle, then hold from the capture registers.
  assign ReadDataM = (stateReg == SRD) ? ramRdata : readDataReg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : gLane
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vecReg[gi] <= '0;
        end else if (capVec && capIdx == 2'(gi)) begin
          vecReg[gi] <= ramRdata;
        end
      end

      if (gi == LANES - 1) begin : gLast
        assign ReadDataVecM[gi] = (stateReg == RESP) ? ramRdata : vecReg[gi];
      end else begin : gMid
        assign ReadDataVecM[gi] = vecReg[gi];
      end
    end
  endgenerate

endmodule
